// File: rtl/fpdiv_pkg.sv
// Shared constants and types for the div/sqrt round-and-pack path.
// Covers binary32 field layout, special encodings, flag bit positions and rounding modes.
package fpdiv_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned EMAX   = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef enum logic {
    RNE = 1'b0,
    RZ  = 1'b1
  } rnd_mode_t;

endpackage

// File: rtl/fpdiv_rounder.sv
// Combinational round/overflow/pack stage: takes a normalized (or denormalized) significand
// with round and sticky bits and produces the packed binary32 result and exception flags.
module fpdiv_rounder
  import fpdiv_pkg::*;
#(
  parameter int unsigned EW = 10
) (
  input  logic [23:0]   m_i,
  input  logic          r_i,
  input  logic          s_i,
  input  logic [EW-1:0] e_i,
  input  logic          tiny_i,
  input  logic          sign_i,
  input  rnd_mode_t     mode_i,
  input  logic          nan_i,
  input  logic          inf_i,
  input  logic          zero_i,
  input  logic          nv_i,
  input  logic          dz_i,
  output logic [31:0]   result_o,
  output logic [4:0]    flags_o
);

  logic              inc;
  logic [24:0]       mr;
  logic [EW:0]       e_r;
  logic [FRAC_W-1:0] frac;
  logic              nx;
  logic              of;
  logic              uf;

  always_comb begin
    inc  = (mode_i == RNE) && r_i && (s_i || m_i[0]);
    mr   = {1'b0, m_i} + {24'b0, inc};
    e_r  = {1'b0, e_i};
    frac = mr[FRAC_W-1:0];
    if (mr[24]) begin
      e_r  = e_r + (EW+1)'(1);
      frac = mr[FRAC_W:1];
    end else if (tiny_i && mr[23]) begin
      // Subnormal rounded up into the hidden bit: becomes the smallest normal
      e_r = (EW+1)'(1);
    end

    nx = r_i | s_i;
    of = (e_r >= (EW+1)'(EMAX));
    uf = tiny_i && nx;
    if (of) begin
      nx = 1'b1;
    end

    result_o = {sign_i, e_r[EXP_W-1:0], frac};
    if (of) begin
      result_o = (mode_i == RNE) ? {sign_i, 8'hFF, 23'h00_0000} : {sign_i, 8'hFE, 23'h7F_FFFF};
    end

    flags_o          = '0;
    flags_o[FLAG_NV] = nv_i;
    flags_o[FLAG_DZ] = dz_i;
    flags_o[FLAG_OF] = of;
    flags_o[FLAG_UF] = uf;
    flags_o[FLAG_NX] = nx;

    if (nan_i || inf_i || zero_i) begin
      flags_o[FLAG_OF] = 1'b0;
      flags_o[FLAG_UF] = 1'b0;
      flags_o[FLAG_NX] = 1'b0;
    end
    if (nan_i) begin
      result_o = QNAN;
    end else if (inf_i) begin
      result_o = {sign_i, 8'hFF, 23'h00_0000};
    end else if (zero_i) begin
      result_o = {sign_i, 31'h0};
    end
  end

endmodule

// File: rtl/fpdiv_round_pack.sv
// Two-stage valid/ready post-processing for the div/sqrt core: stage 1 normalizes and
// denormalizes, stage 2 registers the rounded, packed binary32 result and flags.
module fpdiv_round_pack
  import fpdiv_pkg::*;
#(
  parameter int unsigned QW = 27,
  parameter int unsigned EW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_round_mode,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [QW-1:0] in_q,
  input  logic          in_sticky,
  input  logic          in_nan,
  input  logic          in_inf,
  input  logic          in_zero,
  input  logic          in_nv,
  input  logic          in_dz,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic [4:0]    out_flags
);

  localparam logic signed [EW:0] One   = 1;
  localparam logic signed [EW:0] ShCap = 26;

  logic s1_valid, s2_valid, s1_advance, in_fire;

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_valid  = s2_valid;

  // Stage 1 combinational normalize / denormalize
  logic signed [EW:0] e_pre;
  logic signed [EW:0] sh_amt;
  logic [4:0]         sh;
  logic [50:0]        sh_vec;
  logic [23:0]        n_m;
  logic               n_r, n_s, n_tiny;
  logic [EW-1:0]      n_e;

  always_comb begin
    e_pre = {in_exp[EW-1], in_exp};
    if (in_q[QW-1]) begin
      n_m = in_q[QW-1 -: 24];
      n_r = in_q[QW-25];
      n_s = (|in_q[QW-26:0]) | in_sticky;
    end else begin
      n_m   = in_q[QW-2 -: 24];
      n_r   = in_q[QW-26];
      n_s   = (|in_q[QW-27:0]) | in_sticky;
      e_pre = e_pre - One;
    end
    n_tiny = 1'b0;
    n_e    = e_pre[EW-1:0];
    sh_amt = One - e_pre;
    sh     = '0;
    sh_vec = '0;
    if (e_pre[EW] || (e_pre == '0)) begin
      sh     = (sh_amt > ShCap) ? 5'd26 : sh_amt[4:0];
      sh_vec = {n_m, n_r, 26'b0} >> sh;
      n_m    = sh_vec[50:27];
      n_r    = sh_vec[26];
      n_s    = n_s | (|sh_vec[25:0]);
      n_tiny = 1'b1;
      n_e    = '0;
    end
  end

  logic [23:0]   s1_m;
  logic          s1_r, s1_s, s1_tiny, s1_sign;
  logic [EW-1:0] s1_e;
  rnd_mode_t     s1_mode;
  logic          s1_nan, s1_inf, s1_zero, s1_nv, s1_dz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
      s1_r     <= 1'b0;
      s1_s     <= 1'b0;
      s1_e     <= '0;
      s1_tiny  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mode  <= RNE;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nv    <= 1'b0;
      s1_dz    <= 1'b0;
    end else begin
      s1_valid <= in_fire || (s1_valid && !s1_advance);
      if (in_fire) begin
        s1_m    <= n_m;
        s1_r    <= n_r;
        s1_s    <= n_s;
        s1_e    <= n_e;
        s1_tiny <= n_tiny;
        s1_sign <= in_sign;
        s1_mode <= rnd_mode_t'(in_round_mode);
        s1_nan  <= in_nan;
        s1_inf  <= in_inf;
        s1_zero <= in_zero;
        s1_nv   <= in_nv;
        s1_dz   <= in_dz;
      end
    end
  end

  logic [31:0] rnd_result;
  logic [4:0]  rnd_flags;

  fpdiv_rounder #(
    .EW(EW)
  ) u_rounder (
    .m_i      (s1_m),
    .r_i      (s1_r),
    .s_i      (s1_s),
    .e_i      (s1_e),
    .tiny_i   (s1_tiny),
    .sign_i   (s1_sign),
    .mode_i   (s1_mode),
    .nan_i    (s1_nan),
    .inf_i    (s1_inf),
    .zero_i   (s1_zero),
    .nv_i     (s1_nv),
    .dz_i     (s1_dz),
    .result_o (rnd_result),
    .flags_o  (rnd_flags)
  );

  // Output registers only load on advance, so they hold steady under backpressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= rnd_result;
        out_flags  <= rnd_flags;
      end
    end
  end

endmodule
